// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - register map, bit indices and FSM encoding for the SRAM bus sequencer
package sram_seq_pkg;

   localparam logic [1:0] REG_ADDR   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_GO       = 0;
   localparam int CTRL_AUTO_INC = 1;
   localparam int CTRL_IRQ_EN   = 2;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sram_strobe_timer.sv
// rtl/sram_strobe_timer.sv - strobe-width down counter; last is high while the count sits at zero
module sram_strobe_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       last
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign last = (count == 4'd0);

endmodule

// File: rtl/sram_bus_sequencer.sv
// rtl/sram_bus_sequencer.sv - Avalon-MM slave sequencing single-byte accesses to an async SRAM
module sram_bus_sequencer
   import sram_seq_pkg::*;
#(
   parameter int ADDR_W   = 11,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [7:0]        sram_data,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              op_write_q;
   logic              auto_inc_q, irq_en_q, done_q, err_q;
   logic              oe_int;
   logic              timer_last;
   logic [31:0]       rd_mux;

   logic wr, busy, launch, err_set, hold_exit, sample;
   logic unused_wdata;

   assign wr        = chipselect && !write_n;
   assign busy      = (state_q != S_IDLE);
   assign launch    = wr && ((address == REG_DATA) ||
                             ((address == REG_CTRL) && writedata[CTRL_GO]));
   assign err_set   = busy && (launch || (wr && (address == REG_ADDR)));
   assign hold_exit = (state_q == S_HOLD);
   assign sample    = (state_q == S_STROBE) && !op_write_q && timer_last;
   assign unused_wdata = ^writedata[31:8];

   sram_strobe_timer u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (state_q == S_SETUP),
      .load_val (4'(WAIT_CYC - 1)),
      .last     (timer_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes decode from registered state only, so an async reset releases them at once.
   always_comb begin
      state_d   = state_q;
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
      oe_int    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (launch) state_d = S_SETUP;
         end
         S_SETUP: begin
            state_d   = S_STROBE;
            sram_ce_n = 1'b0;
            oe_int    = op_write_q;
            sram_oe_n = op_write_q;
         end
         S_STROBE: begin
            if (timer_last) state_d = S_HOLD;
            sram_ce_n = 1'b0;
            oe_int    = op_write_q;
            sram_oe_n = op_write_q;
            sram_we_n = !op_write_q;
         end
         S_HOLD: begin
            state_d   = S_IDLE;
            sram_ce_n = !op_write_q;
            oe_int    = op_write_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q     <= '0;
         data_q     <= 8'd0;
         op_write_q <= 1'b0;
         auto_inc_q <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (hold_exit && auto_inc_q) begin
            addr_q <= addr_q + 1'b1;
         end else if (wr && !busy && (address == REG_ADDR)) begin
            addr_q <= writedata[ADDR_W-1:0];
         end

         if (sample) begin
            data_q <= sram_data;
         end else if (wr && !busy && (address == REG_DATA)) begin
            data_q <= writedata[7:0];
         end

         if (launch && !busy) op_write_q <= (address == REG_DATA);

         if (wr && (address == REG_CTRL)) begin
            auto_inc_q <= writedata[CTRL_AUTO_INC];
            irq_en_q   <= writedata[CTRL_IRQ_EN];
         end

         // Set has priority over a simultaneous write-one-to-clear.
         if (hold_exit) begin
            done_q <= 1'b1;
         end else if (wr && (address == REG_STATUS) && writedata[ST_DONE]) begin
            done_q <= 1'b0;
         end

         if (err_set) begin
            err_q <= 1'b1;
         end else if (wr && (address == REG_STATUS) && writedata[ST_ERR]) begin
            err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         REG_ADDR:   rd_mux = 32'(addr_q);
         REG_DATA:   rd_mux = {24'd0, data_q};
         REG_CTRL:   rd_mux = {29'd0, irq_en_q, auto_inc_q, 1'b0};
         REG_STATUS: rd_mux = {29'd0, err_q, done_q, busy};
         default:    rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'd0;
      end else begin
         readdata <= chipselect ? rd_mux : 32'd0;
      end
   end

   assign irq       = done_q && irq_en_q;
   assign sram_addr = addr_q;

   for (genvar i = 0; i < 8; i++) begin : g_bus
      assign sram_data[i] = oe_int ? data_q[i] : 1'bz;
   end

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// tb/tb_sram_bus_sequencer.sv - directed self-checking bench for sram_bus_sequencer
module tb_sram_bus_sequencer;

   localparam int ADDR_W = 11;
   localparam logic [1:0] A_ADDR = 2'd0, A_DATA = 2'd1, A_CTRL = 2'd2, A_STATUS = 2'd3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        address;
   logic              chipselect, write_n;
   logic [31:0]       writedata, readdata;
   logic              irq;
   logic [ADDR_W-1:0] sram_addr;
   wire  [7:0]        sram_data;
   logic              sram_ce_n, sram_oe_n, sram_we_n;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   logic              poke_en;
   logic [ADDR_W-1:0] poke_addr;
   logic [7:0]        poke_val;

   int n_checks = 0, n_errors = 0;
   int we_lo, oe_lo, drv, bad;
   logic [31:0] rd;

   sram_bus_sequencer #(.ADDR_W(ADDR_W), .WAIT_CYC(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   // Async SRAM model: drives on CE&OE, captures on CE&WE.
   assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hzz;

   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_val;
      else if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic avm_wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic avm_rd(input logic [1:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] v);
      poke_addr = a; poke_val = v; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic clr_mon();
      we_lo = 0; oe_lo = 0; drv = 0; bad = 0;
   endtask

   task automatic watch(input int n, input logic [7:0] exp_bus);
      for (int i = 0; i < n; i++) begin
         if (!sram_we_n) we_lo++;
         if (!sram_oe_n) oe_lo++;
         if (dut.oe_int) begin
            drv++;
            if (sram_data !== exp_bus) bad++;
         end
         tick();
      end
   endtask

   initial begin
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
      writedata = 32'd0; poke_en = 1'b0; poke_addr = '0; poke_val = 8'd0;
      tick(3);
      reset_n = 1'b1;
      tick(10);
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
      check("rst_drive", 32'(dut.oe_int), 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      avm_rd(A_STATUS, rd); check("rst_status", rd, 32'd0);
      avm_rd(A_DATA, rd);   check("rst_data", rd, 32'd0);

      // Write 0xA5 to 0x123
      avm_wr(A_CTRL, 32'h4);
      avm_wr(A_ADDR, 32'h123);
      avm_wr(A_DATA, 32'hA5);
      clr_mon();
      watch(3, 8'hA5);
      check("wr_irq_in_hold", 32'(irq), 32'd0);
      watch(1, 8'hA5);
      check("wr_irq_after_4", 32'(irq), 32'd1);
      watch(2, 8'hA5);
      check("wr_we_low_cycles", 32'(we_lo), 32'd2);
      check("wr_drive_cycles", 32'(drv), 32'd4);
      check("wr_bus_value", 32'(bad), 32'd0);
      check("wr_oe_low", 32'(oe_lo), 32'd0);
      check("wr_sram_addr", 32'(sram_addr), 32'h123);
      check("wr_mem", 32'(mem[11'h123]), 32'hA5);
      avm_rd(A_ADDR, rd); check("wr_addr_reg", rd, 32'h123);

      // Read 0x3C back from 0x123
      avm_wr(A_STATUS, 32'h2);
      avm_wr(A_CTRL, 32'h0);
      check("w1c_irq", 32'(irq), 32'd0);
      poke(11'h123, 8'h3C);
      avm_wr(A_CTRL, 32'h1);
      clr_mon();
      watch(6, 8'h00);
      check("rd_oe_low_cycles", 32'(oe_lo), 32'd3);
      check("rd_never_driven", 32'(drv), 32'd0);
      check("rd_we_low", 32'(we_lo), 32'd0);
      avm_rd(A_DATA, rd);   check("rd_data", rd, 32'h3C);
      avm_rd(A_STATUS, rd); check("rd_status", rd, 32'h2);
      avm_rd(A_CTRL, rd);   check("rd_ctrl_go_clear", rd, 32'h0);

      // Auto-increment wraps from the top address
      avm_wr(A_STATUS, 32'h2);
      avm_wr(A_CTRL, 32'h2);
      avm_wr(A_ADDR, 32'h7FF);
      avm_wr(A_DATA, 32'h11);
      tick(5);
      check("inc_mem", 32'(mem[11'h7FF]), 32'h11);
      avm_rd(A_ADDR, rd); check("inc_wrap", rd, 32'h0);
      avm_rd(A_CTRL, rd); check("inc_ctrl", rd, 32'h2);

      // Accesses while busy are rejected and flag err
      avm_wr(A_CTRL, 32'h0);
      avm_wr(A_STATUS, 32'h6);
      avm_wr(A_ADDR, 32'h040);
      avm_wr(A_DATA, 32'h55);
      avm_wr(A_DATA, 32'h99);
      avm_wr(A_ADDR, 32'h0AA);
      avm_wr(A_CTRL, 32'h1);
      tick(4);
      check("busy_mem", 32'(mem[11'h040]), 32'h55);
      avm_rd(A_DATA, rd);   check("busy_data", rd, 32'h55);
      avm_rd(A_ADDR, rd);   check("busy_addr", rd, 32'h040);
      avm_rd(A_STATUS, rd); check("busy_status", rd, 32'h6);
      avm_wr(A_STATUS, 32'h6);
      avm_rd(A_STATUS, rd); check("busy_w1c", rd, 32'h0);

      // done set and W1C on the same edge: set wins
      avm_wr(A_DATA, 32'h66);
      tick(3);
      avm_wr(A_STATUS, 32'h2);
      avm_rd(A_STATUS, rd); check("set_wins_done", rd, 32'h2);
      check("set_wins_mem", 32'(mem[11'h040]), 32'h66);

      // Reset in the middle of a write strobe
      avm_wr(A_STATUS, 32'h2);
      avm_wr(A_ADDR, 32'h010);
      avm_wr(A_DATA, 32'h77);
      tick(1);
      check("mid_we_active", 32'(sram_we_n), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
      check("mid_rst_drive", 32'(dut.oe_int), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(3);
      avm_rd(A_STATUS, rd); check("mid_status", rd, 32'h0);
      check("mid_irq", 32'(irq), 32'd0);
      avm_rd(A_DATA, rd);   check("mid_data", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
